// File: rtl/inst_capture.sv
// ---------------------------------------------------------------------------
// inst_capture
//
// Front end between the execute button / switch bank and the instruction
// sequencer of the stack calculator. The button is synchronized and
// debounced. Each confirmed press captures the synchronized 8-bit switch
// word into a one-entry slot, which is offered downstream through a
// valid/ready handshake.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset; clears every register
//   btn_in    raw execute button, asynchronous to clk
//   sw_in     raw instruction switches, asynchronous to clk
//   inst_rdy  downstream sequencer can accept a word this cycle
//   inst_vld  a captured word is pending on inst_wd
//   inst_wd   captured instruction word
//   inst_cnt  number of accepted transfers, modulo 256
//   ovf       sticky: a press arrived while the slot was full and blocked
//
// Handshake: a transfer happens on every cycle where inst_vld and inst_rdy
// are both 1. inst_vld and inst_wd are registers and never depend
// combinationally on inst_rdy. While inst_vld=1 and no transfer has
// happened, inst_wd holds its value.
//
// Parameters
//   CLK_DIV         clocks per debounce sample tick (>= 2)
//   STABLE_SAMPLES  consecutive differing ticks needed to flip the level (>= 1)
//   CNT_W           tick counter width, 2**CNT_W >= CLK_DIV
// ---------------------------------------------------------------------------
module inst_capture #(
  parameter int CLK_DIV        = 10000,
  parameter int STABLE_SAMPLES = 4,
  parameter int CNT_W          = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic [7:0] sw_in,
  input  logic       inst_rdy,
  output logic       inst_vld,
  output logic [7:0] inst_wd,
  output logic [7:0] inst_cnt,
  output logic       ovf
);

  // Wide enough to hold the count of differing ticks.
  localparam int SC_W = $clog2(STABLE_SAMPLES + 1);

  // Two-flop synchronizers for the button and each switch bit.
  logic       btn_meta;
  logic       btn_s;
  logic [7:0] sw_meta;
  logic [7:0] sw_s;

  // Debounce sample tick.
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  // Debounced level, its one-cycle-delayed copy, and the count of
  // consecutive ticks on which the synchronized button disagreed with it.
  logic [SC_W-1:0] stable_cnt;
  logic            deb;
  logic            deb_q;

  logic press;
  logic xfer;

  assign tick  = (tick_cnt == CNT_W'(CLK_DIV - 1));
  assign press = deb & ~deb_q;
  assign xfer  = inst_vld & inst_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta   <= 1'b0;
      btn_s      <= 1'b0;
      sw_meta    <= 8'h00;
      sw_s       <= 8'h00;
      tick_cnt   <= '0;
      stable_cnt <= '0;
      deb        <= 1'b0;
      deb_q      <= 1'b0;
      inst_vld   <= 1'b0;
      inst_wd    <= 8'h00;
      inst_cnt   <= 8'h00;
      ovf        <= 1'b0;
    end else begin
      btn_meta <= btn_in;
      btn_s    <= btn_meta;
      sw_meta  <= sw_in;
      sw_s     <= sw_meta;

      if (tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end

      // The level only flips after STABLE_SAMPLES consecutive ticks that
      // disagree with it; a single agreeing tick restarts the count, so
      // short glitches never reach deb.
      if (tick) begin
        if (btn_s != deb) begin
          if (stable_cnt == SC_W'(STABLE_SAMPLES - 1)) begin
            deb        <= ~deb;
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + SC_W'(1);
          end
        end else begin
          stable_cnt <= '0;
        end
      end

      deb_q <= deb;

      // The slot counts as free when it is empty or is being drained on
      // this very cycle, so a press coinciding with a transfer reloads it
      // and inst_vld stays high.
      if (press && (!inst_vld || xfer)) begin
        inst_wd  <= sw_s;
        inst_vld <= 1'b1;
      end else if (xfer) begin
        inst_vld <= 1'b0;
      end

      // A press against a full, blocked slot is dropped; the old word stays.
      if (press && inst_vld && !inst_rdy) begin
        ovf <= 1'b1;
      end

      if (xfer) begin
        inst_cnt <= inst_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_capture.sv
// ---------------------------------------------------------------------------
// tb_inst_capture
//
// Bench for inst_capture with CLK_DIV=4, STABLE_SAMPLES=3. Words expected
// downstream are pushed into exp_q when a press is issued; a monitor pops
// and compares on every transfer. The timing model works from the rules
// directly: sample ticks land on edges that are multiples of CLK_DIV after
// reset, the button reaches the debouncer 3 edges after it is driven, and
// the level flips on the STABLE_SAMPLES-th such tick.
// ---------------------------------------------------------------------------
module tb_inst_capture;

  localparam int CLK_DIV = 4;
  localparam int STABLE  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic [7:0] sw_in;
  logic       inst_rdy;
  logic       inst_vld;
  logic [7:0] inst_wd;
  logic [7:0] inst_cnt;
  logic       ovf;

  inst_capture #(
    .CLK_DIV       (CLK_DIV),
    .STABLE_SAMPLES(STABLE),
    .CNT_W         (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .sw_in   (sw_in),
    .inst_rdy(inst_rdy),
    .inst_vld(inst_vld),
    .inst_wd (inst_wd),
    .inst_cnt(inst_cnt),
    .ovf     (ovf)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 clk = ~clk;

  // cyc = number of edges since the last edge that saw rst=1.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         exp_cnt = 0;
  logic       exp_ovf = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops on every transfer and checks the word is held while stalled.
  logic       hold_prev = 1'b0;
  logic [7:0] hold_wd   = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_vld", inst_vld, 1);
        check("hold_wd", inst_wd, hold_wd);
      end
      if (inst_vld && inst_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected: got wd %0h expected no transfer (cyc %0d)", inst_wd, cyc);
        end else begin
          check("xfer_wd", inst_wd, exp_q.pop_front());
        end
      end
      hold_prev = inst_vld && !inst_rdy;
      hold_wd   = inst_wd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    exp_ovf = 1'b0;
  endtask

  // Advance to just after edge n (cyc counts from the last reset).
  task automatic at_cycle(input int n);
    while (cyc < n) idle(1);
    check("timing", cyc, n);
  endtask

  // Press the button with the given switch word. Returns the edge after
  // which the debounced level is high (the press pulse is on the following
  // cycle). Assumes the debouncer is idle at level 0.
  task automatic btn_down(input logic [7:0] sw, output int d);
    int first;
    sw_in  = sw;
    btn_in = 1'b1;
    first  = ((cyc + 3 + CLK_DIV - 1) / CLK_DIV) * CLK_DIV;
    d      = first + (STABLE - 1) * CLK_DIV;
  endtask

  task automatic btn_up(input int gap);
    btn_in = 1'b0;
    idle(gap);
  endtask

  task automatic expect_quiet_until(input int n);
    while (cyc < n) begin
      check("early_vld", inst_vld, 0);
      idle(1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish within 5ms");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d;
    int d2;
    rst      = 1'b1;
    btn_in   = 1'b1;
    sw_in    = 8'hA5;
    inst_rdy = 1'b1;

    // Reset held 3 cycles with the button pressed: outputs stay clear.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_vld", inst_vld, 0);
      check("rst_wd", inst_wd, 0);
      check("rst_cnt", inst_cnt, 0);
      check("rst_ovf", ovf, 0);
    end
    rst = 1'b0;
    exp_q.push_back(8'hA5);
    exp_cnt = 1;
    // Button seen from edge 3; ticks on edges 4, 8, 12; capture on 13.
    expect_quiet_until(12);
    check("rst_early", inst_vld, 0);
    at_cycle(13);
    check("rst_cap_vld", inst_vld, 1);
    check("rst_cap_wd", inst_wd, 8'hA5);
    btn_up(40);
    check("rst_cnt_after", inst_cnt, exp_cnt);

    // Clean press with the sink always ready.
    do_reset(2);
    inst_rdy = 1'b1;
    btn_down(8'h04, d);
    exp_q.push_back(8'h04);
    exp_cnt++;
    at_cycle(d);
    check("clean_early", inst_vld, 0);
    at_cycle(d + 1);
    check("clean_vld", inst_vld, 1);
    check("clean_wd", inst_wd, 8'h04);
    at_cycle(d + 2);
    check("clean_one_cycle", inst_vld, 0);
    idle(28);
    btn_up(40);
    check("clean_cnt", inst_cnt, exp_cnt);
    check("clean_ovf", ovf, 0);
    check("clean_drained", exp_q.size(), 0);

    // Glitches of at most 6 cycles never reach the debounced level.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      btn_in = 1'b1;
      idle((i == 0) ? 6 : $urandom_range(1, 6));
      btn_up(20);
    end
    check("glitch_cnt", inst_cnt, 0);
    check("glitch_vld", inst_vld, 0);

    // Backpressure: first word held, second press dropped and flagged.
    do_reset(1);
    inst_rdy = 1'b0;
    btn_down(8'h4B, d);
    exp_q.push_back(8'h4B);
    exp_cnt++;
    at_cycle(d + 1);
    check("bp_vld", inst_vld, 1);
    check("bp_wd", inst_wd, 8'h4B);
    idle(5);
    btn_up(20);
    for (int i = 0; i < 30; i++) begin
      idle(1);
      check("bp_hold_wd", inst_wd, 8'h4B);
    end
    check("bp_cnt0", inst_cnt, 0);
    btn_down(8'hC0, d2);
    at_cycle(d2);
    check("bp_ovf_before", ovf, 0);
    at_cycle(d2 + 1);
    exp_ovf = 1'b1;
    check("bp_ovf", ovf, exp_ovf);
    check("bp_wd_kept", inst_wd, 8'h4B);
    check("bp_vld_kept", inst_vld, 1);
    btn_up(20);
    inst_rdy = 1'b1;
    idle(3);
    check("bp_cnt", inst_cnt, exp_cnt);
    check("bp_vld_done", inst_vld, 0);
    check("bp_ovf_sticky", ovf, exp_ovf);

    // Transfer and press on the same cycle.
    do_reset(1);
    inst_rdy = 1'b0;
    btn_down(8'h01, d);
    exp_q.push_back(8'h01);
    exp_cnt++;
    at_cycle(d + 1);
    check("sim_first_wd", inst_wd, 8'h01);
    idle(3);
    btn_up(24);
    btn_down(8'h02, d2);
    exp_q.push_back(8'h02);
    exp_cnt++;
    at_cycle(d2);
    inst_rdy = 1'b1;
    at_cycle(d2 + 1);
    check("sim_vld", inst_vld, 1);
    check("sim_wd", inst_wd, 8'h02);
    check("sim_cnt", inst_cnt, 1);
    check("sim_ovf", ovf, 0);
    btn_up(24);
    check("sim_cnt_final", inst_cnt, exp_cnt);
    check("sim_vld_final", inst_vld, 0);

    // 256 random presses with random backpressure: count wraps to 0.
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      int hold;
      w    = 8'($urandom);
      hold = $urandom_range(16, 30);
      btn_down(w, d);
      exp_q.push_back(w);
      exp_cnt++;
      for (int j = 0; j < hold; j++) begin
        inst_rdy = ($urandom_range(0, 3) != 0);
        idle(1);
      end
      inst_rdy = 1'b1;
      btn_up($urandom_range(18, 30));
      if ((i % 4) == 3) begin
        btn_in = 1'b1;
        idle($urandom_range(1, 6));
        btn_up(18);
      end
    end
    check("wrap_cnt", inst_cnt, exp_cnt % 256);
    check("wrap_ovf", ovf, 0);
    check("wrap_drained", exp_q.size(), 0);

    // Reset in the middle of a debounce: a fresh stable interval is needed.
    do_reset(1);
    inst_rdy = 1'b1;
    btn_down(8'h5A, d);
    idle(8);
    do_reset(1);
    exp_q.push_back(8'h5A);
    exp_cnt++;
    expect_quiet_until(12);
    check("mid_rst_early", inst_vld, 0);
    at_cycle(13);
    check("mid_rst_vld", inst_vld, 1);
    check("mid_rst_wd", inst_wd, 8'h5A);
    btn_up(40);
    check("mid_rst_cnt", inst_cnt, exp_cnt);

    // ---------------- report ----------------
    check("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
